lieat_vld_wbasm: RTL and testbench
==================================

# lieat_vld_wbasm

Vector load writeback assembler for the VPU. Accepts one vector-load request (destination group base, element count, element width), collects the returning 32-bit memory beats into an 8-word staging buffer, and writes the whole register group in a single cycle through the vector register file's 8-wide write port. Tail bytes beyond `vl` are never written: their byte-enable bits are forced to 0.

## Interface
Parameters: none (widths come from global defines: `` `XLEN`` = 32, `` `REG_IDX`` = 5).

Ports:
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `ld_req_valid` in 1 — load request valid.
- `ld_req_ready` out 1 — block can accept a request.
- `ld_req_vd` in `` `REG_IDX`` — destination group base register.
- `ld_req_vl` in 6 — element count, 0..32.
- `ld_req_sew` in 2 — element width: 00 = 8b, 01 = 16b, 10 = 32b, 11 = treated as 32b.
- `mem_rvalid` in 1 — memory read beat valid.
- `mem_rready` out 1 — block accepts a beat.
- `mem_rdata` in `` `XLEN`` — beat data, little-endian bytes.
- `vreg_wvalid` out 1 — register-file group write strobe.
- `vreg_rd0` out `` `REG_IDX`` — group base; the register file adds the offset k (mod 32) itself.
- `vreg_wmask0`..`vreg_wmask7` out 4 each — byte enables for group word k.
- `vreg_wdata0`..`vreg_wdata7` out `` `XLEN`` each — data for group word k.
- `ld_done` out 1 — one-cycle completion pulse.

## Operation
- FSM states: IDLE, COLLECT, WRITE.
- **IDLE**
  - `ld_req_ready = 1`.
  - On `ld_req_valid & ld_req_ready`:
    - Latch `vd`.
    - Compute `bytes = min(vl << sewsh, 32)`, where sewsh = 0, 1, 2, 2 for sew = 00, 01, 10, 11.
    - Compute `nwords = (bytes + 3) >> 2`.
    - Clear the beat counter and all 8 staging words.
    - If `nwords == 0`, go to WRITE; otherwise go to COLLECT.
- **COLLECT**
  - `mem_rready = 1`.
  - On each `mem_rvalid & mem_rready`: `word[cnt] <= mem_rdata`, `cnt <= cnt + 1`.
  - On the beat where `cnt == nwords - 1`, go to WRITE.
  - Gaps in `mem_rvalid` are legal; the FSM stays in COLLECT.
- **WRITE** (one cycle, then IDLE)
  - `vreg_wvalid = (nwords != 0)`; `ld_done = 1`.
  - `vreg_wdata_k = word[k]`.
  - `vreg_wmask_k[j] = (4k + j < bytes)`. Words k ≥ nwords therefore get mask 0 and data 0.
- `vreg_rd0` = latched `vd` in all states. Group wrap past v31 is handled by the register file's mod-32 addition.
- `mem_rready` is 0 outside COLLECT. Beats presented in IDLE/WRITE are not consumed.
- `ld_req_ready` is 0 outside IDLE. A request held valid during a busy period is accepted only on return to IDLE.
- vl > 32, or vl·width > 32 bytes: clamped to 32 bytes, 8 words, all masks 0xF.

## Timing
- Reset values: state IDLE, `ld_req_ready = 1`, `mem_rready = 0`, `vreg_wvalid = 0`, `ld_done = 0`, `vreg_rd0 = 0`, all masks 0, all staging/data 0, cnt 0.
- Reset asserted mid-operation abandons the load:
  - No write is issued and no `ld_done` pulse occurs.
  - Staged data is discarded.
  - IDLE is entered the cycle after reset.
- Request accepted in cycle 0:
  - COLLECT begins in cycle 1.
  - With N back-to-back beats in cycles 1..N, WRITE (`vreg_wvalid`, `ld_done`) is in cycle N+1.
  - `ld_req_ready` returns in cycle N+2.
  - Per-beat stalls add one cycle each.
- vl = 0: WRITE in cycle 1 with `vreg_wvalid = 0` and `ld_done = 1`; ready again in cycle 2.
- Outputs `vreg_*` and `ld_done` are registered or decoded from registered state only. There is no combinational path from `mem_*` to `vreg_*`.
- Minimum issue interval is nwords + 2 cycles. No overlap between consecutive loads.

## Test plan
- **Reset defaults:** assert reset 2 cycles, then release → `ld_req_ready = 1`; `mem_rready`, `vreg_wvalid`, `ld_done` = 0; all masks/data 0.
- **Full 32-bit group:** vd = 8, vl = 8, sew = 10, beats 0x11111111..0x88888888 back-to-back → write in cycle 9:
  - `vreg_rd0 = 8`, all masks 0xF.
  - `wdata0 = 0x11111111` … `wdata7 = 0x88888888`.
  - `ld_done = 1` for exactly one cycle.
- **8-bit tail:** vl = 5, sew = 00, beats 0xAABBCCDD, 0x00000EE → nwords = 2, so exactly 2 beats consumed; write shows:
  - `wmask0 = 0xF`, `wmask1 = 0x1`, `wmask2..7 = 0`.
  - `wdata1 = 0x000000EE`, `wdata2..7 = 0`.
- **16-bit with stalls and wrap:** vd = 30, vl = 3, sew = 01, `mem_rvalid` toggled 1,0,0,1 → 2 beats consumed; write 1 cycle after the second beat:
  - `vreg_rd0 = 30`, `wmask0 = 0xF`, `wmask1 = 0x3`.
  - `mem_rready` drops in the WRITE cycle.
- **vl = 0 and busy backpressure:** vl = 0 request → next cycle `ld_done = 1` with `vreg_wvalid = 0`. Then a second request held valid during a 4-beat load → accepted only in the cycle after that load's WRITE.
- **Reset mid-COLLECT:** 8-word load, reset after 3 beats → no `vreg_wvalid` or `ld_done` ever. A following vl = 4, sew = 10 load writes only the new data (`wdata4..7 = 0`).

Source files
------------

// File: rtl/lieat_vld_wbasm.sv
// Vector load writeback assembler: stages up to eight 32-bit beats,
// then writes the whole register group through the 8-wide write port.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module lieat_vld_wbasm (
  input  logic                clock,
  input  logic                reset,
  input  logic                ld_req_valid,
  output logic                ld_req_ready,
  input  logic [`REG_IDX-1:0] ld_req_vd,
  input  logic [5:0]          ld_req_vl,
  input  logic [1:0]          ld_req_sew,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [`XLEN-1:0]    mem_rdata,
  output logic                vreg_wvalid,
  output logic [`REG_IDX-1:0] vreg_rd0,
  output logic [3:0]          vreg_wmask0,
  output logic [3:0]          vreg_wmask1,
  output logic [3:0]          vreg_wmask2,
  output logic [3:0]          vreg_wmask3,
  output logic [3:0]          vreg_wmask4,
  output logic [3:0]          vreg_wmask5,
  output logic [3:0]          vreg_wmask6,
  output logic [3:0]          vreg_wmask7,
  output logic [`XLEN-1:0]    vreg_wdata0,
  output logic [`XLEN-1:0]    vreg_wdata1,
  output logic [`XLEN-1:0]    vreg_wdata2,
  output logic [`XLEN-1:0]    vreg_wdata3,
  output logic [`XLEN-1:0]    vreg_wdata4,
  output logic [`XLEN-1:0]    vreg_wdata5,
  output logic [`XLEN-1:0]    vreg_wdata6,
  output logic [`XLEN-1:0]    vreg_wdata7,
  output logic                ld_done
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [`REG_IDX-1:0] vd_q;
  logic [5:0]          bytes_q;
  logic [3:0]          nwords_q;
  logic [2:0]          cnt_q;
  logic [`XLEN-1:0]    word_q [8];

  logic [1:0] sewsh;
  logic [7:0] raw_bytes;
  logic [5:0] req_bytes;
  logic [3:0] req_nwords;
  logic       accept;
  logic       beat;
  logic       last_beat;
  logic [3:0] mask [8];

  // Request sizing; sew 11 behaves like 32-bit elements.
  always_comb begin
    sewsh = 2'd2;
    unique case (ld_req_sew)
      2'b00:   sewsh = 2'd0;
      2'b01:   sewsh = 2'd1;
      default: sewsh = 2'd2;
    endcase
    raw_bytes  = {2'b00, ld_req_vl} << sewsh;
    req_bytes  = (raw_bytes > 8'd32) ? 6'd32
                                     : raw_bytes[5:0];
    req_nwords = 4'((req_bytes + 6'd3) >> 2);
  end

  assign accept    = ld_req_valid & ld_req_ready;
  assign beat      = mem_rvalid & mem_rready;
  assign last_beat = ({1'b0, cnt_q} == nwords_q - 4'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ld_req_ready = 1'b0;
    mem_rready   = 1'b0;
    vreg_wvalid  = 1'b0;
    ld_done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld_req_ready = 1'b1;
        if (ld_req_valid) begin
          state_d = (req_nwords == 4'd0) ? WRITE
                                         : COLLECT;
        end
      end
      COLLECT: begin
        mem_rready = 1'b1;
        if (mem_rvalid && last_beat) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        vreg_wvalid = (nwords_q != 4'd0);
        ld_done     = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Staging is cleared on accept so words past nwords write as zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      vd_q     <= '0;
      bytes_q  <= '0;
      nwords_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < 8; k++) begin
        word_q[k] <= '0;
      end
    end else if (accept) begin
      vd_q     <= ld_req_vd;
      bytes_q  <= req_bytes;
      nwords_q <= req_nwords;
      cnt_q    <= '0;
      for (int k = 0; k < 8; k++) begin
        word_q[k] <= '0;
      end
    end else if (beat) begin
      word_q[cnt_q] <= mem_rdata;
      cnt_q         <= cnt_q + 3'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      mask[k] = 4'h0;
    end
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        mask[k][j] = (state_q == WRITE) &&
                     ((k * 4 + j) < int'(bytes_q));
      end
    end
  end

  assign vreg_rd0 = vd_q;

  assign vreg_wmask0 = mask[0];
  assign vreg_wmask1 = mask[1];
  assign vreg_wmask2 = mask[2];
  assign vreg_wmask3 = mask[3];
  assign vreg_wmask4 = mask[4];
  assign vreg_wmask5 = mask[5];
  assign vreg_wmask6 = mask[6];
  assign vreg_wmask7 = mask[7];

  assign vreg_wdata0 = word_q[0];
  assign vreg_wdata1 = word_q[1];
  assign vreg_wdata2 = word_q[2];
  assign vreg_wdata3 = word_q[3];
  assign vreg_wdata4 = word_q[4];
  assign vreg_wdata5 = word_q[5];
  assign vreg_wdata6 = word_q[6];
  assign vreg_wdata7 = word_q[7];

endmodule

// File: tb/tb_lieat_vld_wbasm.sv
// Bench for lieat_vld_wbasm: directed scenarios plus random loads,
// write results checked by a scoreboard monitor.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX
`define REG_IDX 5
`endif

module tb_lieat_vld_wbasm;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ld_req_valid = 1'b0;
  logic        ld_req_ready;
  logic [4:0]  ld_req_vd = '0;
  logic [5:0]  ld_req_vl = '0;
  logic [1:0]  ld_req_sew = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic [31:0] mem_rdata = '0;
  logic        vreg_wvalid;
  logic [4:0]  vreg_rd0;
  logic [3:0]  wm [8];
  logic [31:0] wd [8];
  logic        ld_done;

  lieat_vld_wbasm dut (
    .clock(clock), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_vd(ld_req_vd), .ld_req_vl(ld_req_vl),
    .ld_req_sew(ld_req_sew),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata),
    .vreg_wvalid(vreg_wvalid), .vreg_rd0(vreg_rd0),
    .vreg_wmask0(wm[0]), .vreg_wmask1(wm[1]),
    .vreg_wmask2(wm[2]), .vreg_wmask3(wm[3]),
    .vreg_wmask4(wm[4]), .vreg_wmask5(wm[5]),
    .vreg_wmask6(wm[6]), .vreg_wmask7(wm[7]),
    .vreg_wdata0(wd[0]), .vreg_wdata1(wd[1]),
    .vreg_wdata2(wd[2]), .vreg_wdata3(wd[3]),
    .vreg_wdata4(wd[4]), .vreg_wdata5(wd[5]),
    .vreg_wdata6(wd[6]), .vreg_wdata7(wd[7]),
    .ld_done(ld_done)
  );

  always #5 clock = ~clock;

  typedef logic [7:0][31:0] beats_t;
  typedef struct packed {
    logic [4:0]       vd;
    logic             wv;
    logic [7:0][3:0]  m;
    logic [7:0][31:0] d;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte count clamped at 32, one mask bit per live byte.
  function automatic exp_t model(input logic [4:0] vd,
                                 input int vl, input int sew,
                                 input beats_t b, output int nw);
    exp_t e;
    int w;
    int bytes;
    w = (sew == 0) ? 1 : (sew == 1) ? 2 : 4;
    bytes = vl * w;
    if (bytes > 32) bytes = 32;
    nw = (bytes + 3) / 4;
    e.vd = vd;
    e.wv = (nw != 0);
    for (int k = 0; k < 8; k++) begin
      e.d[k] = (k < nw) ? b[k] : 32'h0;
      for (int j = 0; j < 4; j++) e.m[k][j] = (4 * k + j < bytes);
    end
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clock) begin
    if (!reset && ld_done) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got ld_done=1 expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("wvalid", 32'(vreg_wvalid), 32'(e.wv));
        chk("rd0", 32'(vreg_rd0), 32'(e.vd));
        for (int k = 0; k < 8; k++) begin
          chk($sformatf("wmask%0d", k), 32'(wm[k]), 32'(e.m[k]));
          chk($sformatf("wdata%0d", k), wd[k], e.d[k]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] vd, input int vl,
                       input int sew);
    int n = 0;
    ld_req_vd    = vd;
    ld_req_vl    = 6'(vl);
    ld_req_sew   = 2'(sew);
    ld_req_valid = 1'b1;
    while (ld_req_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got ready=0 expected 1");
    end
    step();
    ld_req_valid = 1'b0;
  endtask

  task automatic feed(input int nw, input beats_t b, input int gap);
    for (int i = 0; i < nw; i++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      if (i > 0) begin
        repeat (g) begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          step();
        end
      end
      mem_rvalid = 1'b1;
      mem_rdata  = b[i];
      chk("mem_rready_collect", 32'(mem_rready), 32'd1);
      chk("req_ready_busy", 32'(ld_req_ready), 32'd0);
      step();
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic write_chk(input int nw);
    chk("ld_done_write", 32'(ld_done), 32'd1);
    chk("wvalid_write", 32'(vreg_wvalid), 32'(nw != 0));
    chk("mem_rready_write", 32'(mem_rready), 32'd0);
    chk("req_ready_write", 32'(ld_req_ready), 32'd0);
  endtask

  task automatic run_load(input logic [4:0] vd, input int vl,
                          input int sew, input beats_t b,
                          input int gap);
    int nw;
    sbq.push_back(model(vd, vl, sew, b, nw));
    issue(vd, vl, sew);
    feed(nw, b, gap);
    write_chk(nw);
    step();
    chk("ld_done_pulse", 32'(ld_done), 32'd0);
    chk("req_ready_back", 32'(ld_req_ready), 32'd1);
  endtask

  beats_t b;
  beats_t b2;
  int nwa;
  int nwb;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst_req_ready", 32'(ld_req_ready), 32'd1);
    chk("rst_mem_rready", 32'(mem_rready), 32'd0);
    chk("rst_wvalid", 32'(vreg_wvalid), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_rd0", 32'(vreg_rd0), 32'd0);
    for (int k = 0; k < 8; k++) begin
      chk("rst_mask", 32'(wm[k]), 32'd0);
      chk("rst_data", wd[k], 32'd0);
    end

    // Full 32-bit group
    for (int i = 0; i < 8; i++) b[i] = 32'h11111111 * (i + 1);
    run_load(5'd8, 8, 2, b, 0);

    // 8-bit tail
    for (int i = 0; i < 8; i++) b[i] = 32'hDEAD0000 + i;
    b[0] = 32'hAABBCCDD;
    b[1] = 32'h000000EE;
    run_load(5'd3, 5, 0, b, 0);

    // 16-bit with two-cycle stall and group wrap
    b[0] = 32'h12345678;
    b[1] = 32'h9ABCDEF0;
    run_load(5'd30, 3, 1, b, 2);

    // vl = 0
    run_load(5'd5, 0, 1, b, 0);

    // Request held during a busy 4-beat load
    for (int i = 0; i < 8; i++) b[i] = $urandom;
    for (int i = 0; i < 8; i++) b2[i] = $urandom;
    sbq.push_back(model(5'd12, 4, 2, b, nwa));
    sbq.push_back(model(5'd20, 2, 2, b2, nwb));
    issue(5'd12, 4, 2);
    ld_req_vd    = 5'd20;
    ld_req_vl    = 6'd2;
    ld_req_sew   = 2'd2;
    ld_req_valid = 1'b1;
    feed(nwa, b, 0);
    write_chk(nwa);
    step();
    chk("held_req_ready_idle", 32'(ld_req_ready), 32'd1);
    step();
    chk("held_req_accepted", 32'(ld_req_ready), 32'd0);
    chk("held_req_collect", 32'(mem_rready), 32'd1);
    ld_req_valid = 1'b0;
    feed(nwb, b2, 0);
    write_chk(nwb);
    step();

    // Reset after 3 of 8 beats
    for (int i = 0; i < 8; i++) b[i] = $urandom | 32'h1;
    issue(5'd7, 8, 2);
    feed(3, b, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_ready", 32'(ld_req_ready), 32'd1);
    chk("midrst_wvalid", 32'(vreg_wvalid), 32'd0);
    chk("midrst_done", 32'(ld_done), 32'd0);
    chk("midrst_rd0", 32'(vreg_rd0), 32'd0);
    for (int i = 0; i < 8; i++) b[i] = 32'hC0DE0000 + i;
    run_load(5'd9, 4, 2, b, 0);

    // Random loads, including vl values that clamp
    repeat (40) begin
      for (int i = 0; i < 8; i++) b[i] = $urandom;
      run_load(5'($urandom), int'($urandom_range(0, 63)),
               int'($urandom_range(0, 3)), b, -1);
    end

    repeat (3) step();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
